// File: rtl/note_input.sv
// Front-panel input controller: synchronises and debounces the push-buttons, auto-repeats the
// note buttons, and applies the resulting events to the registered note/octave/track state.
module note_input #(
    parameter int unsigned TICK_DIV         = 50000,
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter int unsigned REPEAT_DELAY     = 500,
    parameter int unsigned REPEAT_RATE      = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_note_up,
    input  logic       btn_note_dn,
    input  logic       btn_oct_up,
    input  logic       btn_oct_dn,
    input  logic       btn_acc,
    input  logic       btn_track,
    input  logic       btn_play,
    output logic [2:0] note,
    output logic [1:0] octave,
    output logic       accident,
    output logic       current_track,
    output logic [1:0] track_playing,
    output logic       changed
);

    localparam int unsigned NB   = 7;
    localparam int unsigned DS   = DEBOUNCE_SAMPLES;
    localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW   = $clog2(RMAX + 1);

    localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DelayLast = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RateLast  = CW'(REPEAT_RATE);

    // Button index order: 0 note_up, 1 note_dn, 2 oct_up, 3 oct_dn, 4 acc, 5 track, 6 play.
    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

    logic [NB-1:0]         btn_raw;
    logic [NB-1:0]         sync1_q, sync2_q;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic                  tick;
    logic [NB-1:0][DS-1:0] hist_q, hist_d;
    logic [NB-1:0]         level_q, level_d;
    logic [NB-1:0]         press;
    rpt_state_e            rpt_state_q [2];
    rpt_state_e            rpt_state_d [2];
    logic [CW-1:0]         rpt_cnt_q [2];
    logic [CW-1:0]         rpt_cnt_d [2];
    logic [CW-1:0]         rpt_inc [2];
    logic [1:0]            step;
    logic [NB-1:0]         ev_q, ev_d;

    logic [2:0] note_q, note_d;
    logic [1:0] octave_q, octave_d;
    logic       accident_q, accident_d;
    logic       track_q, track_d;
    logic [1:0] playing_q, playing_d;
    logic       changed_q, changed_d;

    assign btn_raw = {btn_play, btn_track, btn_acc, btn_oct_dn, btn_oct_up,
                      btn_note_dn, btn_note_up};

    assign tick       = (tick_cnt_q == TickLast);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (tick) begin
            for (int i = 0; i < NB; i++) begin
                hist_d[i] = (hist_q[i] << 1) | DS'(sync2_q[i]);
                if (hist_d[i] == {DS{sync2_q[i]}} && sync2_q[i] != level_q[i]) begin
                    level_d[i] = sync2_q[i];
                end
            end
        end
    end

    assign press = level_d & ~level_q;

    // Auto-repeat for the two note buttons; release is taken from the debounced level.
    always_comb begin
        step = '0;
        for (int i = 0; i < 2; i++) begin
            rpt_state_d[i] = rpt_state_q[i];
            rpt_cnt_d[i]   = rpt_cnt_q[i];
            rpt_inc[i]     = rpt_cnt_q[i] + 1'b1;
            case (rpt_state_q[i])
                StIdle: begin
                    if (press[i]) begin
                        step[i]        = 1'b1;
                        rpt_state_d[i] = StDelay;
                        rpt_cnt_d[i]   = '0;
                    end
                end
                StDelay: begin
                    if (!level_q[i]) begin
                        rpt_state_d[i] = StIdle;
                    end else if (tick) begin
                        if (rpt_inc[i] == DelayLast) begin
                            step[i]        = 1'b1;
                            rpt_state_d[i] = StRepeat;
                            rpt_cnt_d[i]   = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_inc[i];
                        end
                    end
                end
                StRepeat: begin
                    if (!level_q[i]) begin
                        rpt_state_d[i] = StIdle;
                    end else if (tick) begin
                        if (rpt_inc[i] == RateLast) begin
                            step[i]      = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_inc[i];
                        end
                    end
                end
                default: rpt_state_d[i] = StIdle;
            endcase
        end
    end

    assign ev_d = {press[NB-1:2], step};

    always_comb begin
        note_d     = note_q;
        octave_d   = octave_q;
        accident_d = accident_q;
        track_d    = track_q;
        playing_d  = playing_q;

        if (ev_q[4]) accident_d = ~accident_q;
        // A note change overrides an accidental toggle in the same cycle.
        if (ev_q[0] && !ev_q[1]) begin
            note_d     = (note_q == 3'd6) ? 3'd0 : note_q + 3'd1;
            accident_d = 1'b0;
        end else if (ev_q[1] && !ev_q[0]) begin
            note_d     = (note_q == 3'd0) ? 3'd6 : note_q - 3'd1;
            accident_d = 1'b0;
        end

        if (ev_q[2] && !ev_q[3] && octave_q != 2'd3) octave_d = octave_q + 2'd1;
        if (ev_q[3] && !ev_q[2] && octave_q != 2'd0) octave_d = octave_q - 2'd1;

        if (ev_q[6]) playing_d[track_q] = ~playing_q[track_q];
        if (ev_q[5]) track_d = ~track_q;

        changed_d = (note_d != note_q) || (octave_d != octave_q) ||
                    (accident_d != accident_q) || (track_d != track_q) ||
                    (playing_d != playing_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            tick_cnt_q  <= '0;
            hist_q      <= '0;
            level_q     <= '0;
            ev_q        <= '0;
            for (int i = 0; i < 2; i++) begin
                rpt_state_q[i] <= StIdle;
                rpt_cnt_q[i]   <= '0;
            end
            note_q      <= 3'd0;
            octave_q    <= 2'd1;
            accident_q  <= 1'b0;
            track_q     <= 1'b0;
            playing_q   <= 2'b00;
            changed_q   <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            tick_cnt_q  <= tick_cnt_d;
            hist_q      <= hist_d;
            level_q     <= level_d;
            ev_q        <= ev_d;
            for (int i = 0; i < 2; i++) begin
                rpt_state_q[i] <= rpt_state_d[i];
                rpt_cnt_q[i]   <= rpt_cnt_d[i];
            end
            note_q      <= note_d;
            octave_q    <= octave_d;
            accident_q  <= accident_d;
            track_q     <= track_d;
            playing_q   <= playing_d;
            changed_q   <= changed_d;
        end
    end

    assign note          = note_q;
    assign octave        = octave_q;
    assign accident      = accident_q;
    assign current_track = track_q;
    assign track_playing = playing_q;
    assign changed       = changed_q;

endmodule

// File: tb/tb_note_input.sv
// Directed bench for note_input with a fast tick (4 cycles), 3-sample debounce and
// short repeat timing; expected values are worked out by hand per step.
module tb_note_input;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] btn = '0;
    logic [2:0] note;
    logic [1:0] octave;
    logic       accident;
    logic       current_track;
    logic [1:0] track_playing;
    logic       changed;

    int checks   = 0;
    int failures = 0;
    int chg_cnt  = 0;
    int base;
    int w;

    note_input #(
        .TICK_DIV        (4),
        .DEBOUNCE_SAMPLES(3),
        .REPEAT_DELAY    (5),
        .REPEAT_RATE     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_note_up  (btn[0]),
        .btn_note_dn  (btn[1]),
        .btn_oct_up   (btn[2]),
        .btn_oct_dn   (btn[3]),
        .btn_acc      (btn[4]),
        .btn_track    (btn[5]),
        .btn_play     (btn[6]),
        .note         (note),
        .octave       (octave),
        .accident     (accident),
        .current_track(current_track),
        .track_playing(track_playing),
        .changed      (changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (changed === 1'b1) chg_cnt <= chg_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int b, input int hold, input int gap);
        btn[b] = 1'b1;
        cycles(hold);
        btn[b] = 1'b0;
        cycles(gap);
    endtask

    // Waits (bounded) for the next changed strobe; returns the number of cycles waited.
    task automatic wait_chg(input string tag, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (changed !== 1'b1 && waited < 400);
        chk(tag, int'(changed), 1);
    endtask

    initial begin
        // 1: reset and idle
        cycles(3);
        rst = 1'b0;
        cycles(100);
        chk("rst_note", int'(note), 0);
        chk("rst_octave", int'(octave), 1);
        chk("rst_accident", int'(accident), 0);
        chk("rst_track", int'(current_track), 0);
        chk("rst_playing", int'(track_playing), 0);
        chk("rst_no_changed", chg_cnt, 0);

        // 2: seven short note_up presses wrap the note around
        base = chg_cnt;
        for (int i = 0; i < 7; i++) begin
            tap(0, 16, 80);
            chk("note_up_step", int'(note), (i + 1) % 7);
        end
        chk("note_up_changed_cnt", chg_cnt - base, 7);

        // 2b: one-tick bounces never debounce
        base = chg_cnt;
        for (int i = 0; i < 5; i++) begin
            btn[2] = 1'b1;
            cycles(4);
            btn[2] = 1'b0;
            cycles(4);
        end
        cycles(40);
        chk("bounce_octave", int'(octave), 1);
        chk("bounce_changed_cnt", chg_cnt - base, 0);

        // 3: accidental then note_dn clears it in the same cycle
        tap(4, 16, 80);
        chk("acc_set", int'(accident), 1);
        base = chg_cnt;
        btn[1] = 1'b1;
        wait_chg("note_dn_seen", w);
        chk("note_dn_wrap", int'(note), 6);
        chk("note_dn_clears_acc", int'(accident), 0);
        btn[1] = 1'b0;
        cycles(80);
        chk("note_dn_changed_cnt", chg_cnt - base, 1);

        // 3b: octave saturates at 3 with no strobe once saturated
        base = chg_cnt;
        tap(2, 16, 80);
        chk("oct_up_1", int'(octave), 2);
        tap(2, 16, 80);
        chk("oct_up_2", int'(octave), 3);
        tap(2, 16, 80);
        chk("oct_up_3", int'(octave), 3);
        tap(2, 16, 80);
        chk("oct_up_4", int'(octave), 3);
        chk("oct_changed_cnt", chg_cnt - base, 2);

        // 4: hold note_up 9 ticks past the press -> steps at 0, 5, 7, 9
        base = chg_cnt;
        btn[0] = 1'b1;
        wait_chg("hold_first_step", w);
        cycles(22);
        btn[0] = 1'b0;
        cycles(80);
        chk("hold_note", int'(note), 3);
        chk("hold_changed_cnt", chg_cnt - base, 4);

        // 5: track and play together act on the old track
        base = chg_cnt;
        btn[5] = 1'b1;
        btn[6] = 1'b1;
        cycles(16);
        btn[5] = 1'b0;
        btn[6] = 1'b0;
        cycles(80);
        chk("tp_playing", int'(track_playing), 1);
        chk("tp_track", int'(current_track), 1);
        chk("tp_changed_cnt", chg_cnt - base, 1);
        tap(6, 16, 80);
        chk("play_playing", int'(track_playing), 3);

        // 6: reset while held in repeat; button is seen again as a fresh press
        btn[0] = 1'b1;
        wait_chg("pre_rst_press", w);
        cycles(30);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        chk("rst2_note", int'(note), 0);
        chk("rst2_octave", int'(octave), 1);
        chk("rst2_accident", int'(accident), 0);
        chk("rst2_track", int'(current_track), 0);
        chk("rst2_playing", int'(track_playing), 0);
        chk("rst2_changed", int'(changed), 0);
        wait_chg("post_rst_press", w);
        chk("post_rst_note", int'(note), 1);
        wait_chg("post_rst_delay", w);
        chk("post_rst_delay_gap", w, 20);
        chk("post_rst_delay_note", int'(note), 2);
        btn[0] = 1'b0;
        cycles(80);
        chk("post_rst_final_note", int'(note), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
